// File: rtl/baccarat_card_datapath.sv
// Baccarat card datapath: deals cards from a deterministic source on the controller's
// load strobes, enforces the legal dealing order and scores both hands combinationally.
module baccarat_card_datapath #(
    parameter int CARD_INIT = 1,
    parameter int STEP      = 1
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pcard3_out,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [2:0] cards_dealt,
    output logic       seq_error,
    output logic [2:0] phase_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GOT_P1 = 3'd1,
        GOT_D1 = 3'd2,
        GOT_P2 = 3'd3,
        GOT_D2 = 3'd4,
        GOT_P3 = 3'd5,
        DONE   = 3'd6
    } phase_t;

    localparam logic [3:0] INIT4 = 4'(CARD_INIT);
    localparam logic [4:0] STEP5 = 5'(STEP);

    // One-hot strobe codes, bit order {d3,d2,d1,p3,p2,p1}.
    localparam logic [5:0] S_P1 = 6'b000001;
    localparam logic [5:0] S_P2 = 6'b000010;
    localparam logic [5:0] S_P3 = 6'b000100;
    localparam logic [5:0] S_D1 = 6'b001000;
    localparam logic [5:0] S_D2 = 6'b010000;
    localparam logic [5:0] S_D3 = 6'b100000;

    phase_t     phase_q, phase_d, phase_nx;
    logic [3:0] card_q, card_d;
    logic [3:0] pcard_q [3];
    logic [3:0] pcard_d [3];
    logic [3:0] dcard_q [3];
    logic [3:0] dcard_d [3];
    logic [2:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic [5:0] strobes;
    logic       legal;
    logic [4:0] card_sum;

    function automatic logic [4:0] card_val(input logic [3:0] c);
        return (c <= 4'd9) ? {1'b0, c} : 5'd0;
    endfunction

    function automatic logic [3:0] mod10(input logic [4:0] s);
        logic [4:0] r;
        r = s;
        if (r >= 5'd20)      r = r - 5'd20;
        else if (r >= 5'd10) r = r - 5'd10;
        return r[3:0];
    endfunction

    always_comb begin
        phase_d  = phase_q;
        pcard_d  = pcard_q;
        dcard_d  = dcard_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        legal    = 1'b0;
        phase_nx = phase_q;
        strobes  = {load_dcard3, load_dcard2, load_dcard1,
                    load_pcard3, load_pcard2, load_pcard1};

        // Card source steps through 1..13 modulo 13.
        card_sum = {1'b0, card_q} - 5'd1 + STEP5;
        if (card_sum >= 5'd13) card_sum = card_sum - 5'd13;
        card_d = card_sum[3:0] + 4'd1;

        case (phase_q)
            IDLE:   if (strobes == S_P1) begin legal = 1'b1; phase_nx = GOT_P1; end
            GOT_P1: if (strobes == S_D1) begin legal = 1'b1; phase_nx = GOT_D1; end
            GOT_D1: if (strobes == S_P2) begin legal = 1'b1; phase_nx = GOT_P2; end
            GOT_P2: if (strobes == S_D2) begin legal = 1'b1; phase_nx = GOT_D2; end
            GOT_D2: begin
                if (strobes == S_P3) begin legal = 1'b1; phase_nx = GOT_P3; end
                if (strobes == S_D3) begin legal = 1'b1; phase_nx = DONE;   end
            end
            GOT_P3: if (strobes == S_D3) begin legal = 1'b1; phase_nx = DONE; end
            default: legal = 1'b0;
        endcase

        if (strobes != 6'd0) begin
            if (legal) begin
                phase_d = phase_nx;
                cnt_d   = (cnt_q == 3'd6) ? 3'd6 : cnt_q + 3'd1;
                case (strobes)
                    S_P1:    pcard_d[0] = card_q;
                    S_P2:    pcard_d[1] = card_q;
                    S_P3:    pcard_d[2] = card_q;
                    S_D1:    dcard_d[0] = card_q;
                    S_D2:    dcard_d[1] = card_q;
                    S_D3:    dcard_d[2] = card_q;
                    default: ;
                endcase
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            phase_q <= IDLE;
            card_q  <= INIT4;
            pcard_q <= '{default: 4'd0};
            dcard_q <= '{default: 4'd0};
            cnt_q   <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            card_q  <= card_d;
            pcard_q <= pcard_d;
            dcard_q <= dcard_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign pcard1      = pcard_q[0];
    assign pcard2      = pcard_q[1];
    assign pcard3      = pcard_q[2];
    assign dcard1      = dcard_q[0];
    assign dcard2      = dcard_q[1];
    assign dcard3      = dcard_q[2];
    assign pcard3_out  = pcard_q[2];
    assign pscore      = mod10(card_val(pcard_q[0]) + card_val(pcard_q[1]) + card_val(pcard_q[2]));
    assign dscore      = mod10(card_val(dcard_q[0]) + card_val(dcard_q[1]) + card_val(dcard_q[2]));
    assign cards_dealt = cnt_q;
    assign seq_error   = err_q;
    assign phase_dbg   = phase_q;

endmodule

// File: tb/tb_baccarat_card_datapath.sv
// Directed bench for baccarat_card_datapath: a vector table on the default instance
// plus a hand-written deal on an INIT=7/STEP=5 instance.
module tb_baccarat_card_datapath;

    localparam logic [5:0] NO = 6'b000000;
    localparam logic [5:0] P1 = 6'b000001;
    localparam logic [5:0] P2 = 6'b000010;
    localparam logic [5:0] P3 = 6'b000100;
    localparam logic [5:0] D1 = 6'b001000;
    localparam logic [5:0] D2 = 6'b010000;
    localparam logic [5:0] D3 = 6'b100000;

    logic       slow_clock = 1'b0;
    logic       resetb = 1'b0;
    logic [5:0] ld = 6'd0;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pcard3_out, pscore, dscore;
    logic [2:0] cards_dealt, phase_dbg;
    logic       seq_error;

    logic       resetb5 = 1'b0;
    logic [5:0] ld5 = 6'd0;
    logic [3:0] p1_5, p2_5, p3_5, d1_5, d2_5, d3_5, p3o_5, ps_5, ds_5;
    logic [2:0] cd_5, ph_5;
    logic       err_5;

    int n_cmp = 0;
    int n_err = 0;

    always #5 slow_clock = ~slow_clock;

    baccarat_card_datapath u_dut (
        .slow_clock(slow_clock), .resetb(resetb),
        .load_pcard1(ld[0]), .load_pcard2(ld[1]), .load_pcard3(ld[2]),
        .load_dcard1(ld[3]), .load_dcard2(ld[4]), .load_dcard3(ld[5]),
        .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
        .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
        .pcard3_out(pcard3_out), .pscore(pscore), .dscore(dscore),
        .cards_dealt(cards_dealt), .seq_error(seq_error), .phase_dbg(phase_dbg)
    );

    baccarat_card_datapath #(.CARD_INIT(7), .STEP(5)) u_dut5 (
        .slow_clock(slow_clock), .resetb(resetb5),
        .load_pcard1(ld5[0]), .load_pcard2(ld5[1]), .load_pcard3(ld5[2]),
        .load_dcard1(ld5[3]), .load_dcard2(ld5[4]), .load_dcard3(ld5[5]),
        .pcard1(p1_5), .pcard2(p2_5), .pcard3(p3_5),
        .dcard1(d1_5), .dcard2(d2_5), .dcard3(d3_5),
        .pcard3_out(p3o_5), .pscore(ps_5), .dscore(ds_5),
        .cards_dealt(cd_5), .seq_error(err_5), .phase_dbg(ph_5)
    );

    typedef struct {
        int         idle;
        logic       rst_n;
        logic [5:0] ld;
        logic [3:0] p1, p2, p3, d1, d2, d3, ps, ds;
        logic [2:0] cd;
        logic       err;
        logic [2:0] ph;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int idle, input int rst_n, input logic [5:0] l,
                       input int p1, input int p2, input int p3,
                       input int d1, input int d2, input int d3,
                       input int ps, input int ds, input int cd, input int err, input int ph);
        vec_t v;
        v.idle = idle;       v.rst_n = 1'(rst_n); v.ld = l;
        v.p1 = 4'(p1);       v.p2 = 4'(p2);       v.p3 = 4'(p3);
        v.d1 = 4'(d1);       v.d2 = 4'(d2);       v.d3 = 4'(d3);
        v.ps = 4'(ps);       v.ds = 4'(ds);       v.cd = 3'(cd);
        v.err = 1'(err);     v.ph = 3'(ph);
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        // idle rst ld   p1 p2 p3 d1 d2 d3 ps ds cd err ph
        add(0, 0, NO,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // reset state
        add(0, 1, P1,  1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        add(0, 1, D1,  1, 0, 0, 2, 0, 0, 1, 2, 2, 0, 2);
        add(0, 1, P2,  1, 3, 0, 2, 0, 0, 4, 2, 3, 0, 3);
        add(0, 1, D2,  1, 3, 0, 2, 4, 0, 4, 6, 4, 0, 4);
        add(0, 1, D3,  1, 3, 0, 2, 4, 5, 4, 1, 5, 0, 6);   // dealer third, straight to DONE
        add(0, 1, P3,  1, 3, 0, 2, 4, 5, 4, 1, 5, 1, 6);   // P3 after D3 rejected
        add(0, 1, NO,  1, 3, 0, 2, 4, 5, 4, 1, 5, 1, 6);   // error is sticky
        add(0, 0, D2,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, P2,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);   // out-of-order first strobe
        add(0, 1, P1,  2, 0, 0, 0, 0, 0, 2, 0, 1, 1, 1);   // P1 still accepted
        add(0, 0, NO,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, P1|D1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); // two strobes at once
        add(0, 0, NO,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(9, 1, P1, 10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);   // card source reaches 10
        add(0, 1, D1, 10, 0, 0,11, 0, 0, 0, 0, 2, 0, 2);
        add(0, 1, P2, 10,12, 0,11, 0, 0, 0, 0, 3, 0, 3);
        add(0, 1, D2, 10,12, 0,11,13, 0, 0, 0, 4, 0, 4);
        add(0, 1, P3, 10,12, 1,11,13, 0, 1, 0, 5, 0, 5);   // 13 wraps to 1
        add(0, 1, D3, 10,12, 1,11,13, 2, 1, 2, 6, 0, 6);
        add(0, 1, P1, 10,12, 1,11,13, 2, 1, 2, 6, 1, 6);   // strobe in DONE
        add(0, 0, NO,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, P1,  1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        add(0, 1, D1,  1, 0, 0, 2, 0, 0, 1, 2, 2, 0, 2);
        add(0, 1, P2,  1, 3, 0, 2, 0, 0, 4, 2, 3, 0, 3);
        add(0, 0, D2,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // reset wins over D2
        add(0, 1, P1,  1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);   // card source back at INIT

        foreach (vq[i]) begin
            repeat (vq[i].idle) begin
                resetb = 1'b1;
                ld     = NO;
                @(posedge slow_clock); #1;
            end
            resetb = vq[i].rst_n;
            ld     = vq[i].ld;
            @(posedge slow_clock); #1;
            chk($sformatf("v%0d.pcard1", i), 8'(pcard1), 8'(vq[i].p1));
            chk($sformatf("v%0d.pcard2", i), 8'(pcard2), 8'(vq[i].p2));
            chk($sformatf("v%0d.pcard3", i), 8'(pcard3), 8'(vq[i].p3));
            chk($sformatf("v%0d.pcard3_out", i), 8'(pcard3_out), 8'(vq[i].p3));
            chk($sformatf("v%0d.dcard1", i), 8'(dcard1), 8'(vq[i].d1));
            chk($sformatf("v%0d.dcard2", i), 8'(dcard2), 8'(vq[i].d2));
            chk($sformatf("v%0d.dcard3", i), 8'(dcard3), 8'(vq[i].d3));
            chk($sformatf("v%0d.pscore", i), 8'(pscore), 8'(vq[i].ps));
            chk($sformatf("v%0d.dscore", i), 8'(dscore), 8'(vq[i].ds));
            chk($sformatf("v%0d.cards_dealt", i), 8'(cards_dealt), 8'(vq[i].cd));
            chk($sformatf("v%0d.seq_error", i), 8'(seq_error), 8'(vq[i].err));
            chk($sformatf("v%0d.phase", i), 8'(phase_dbg), 8'(vq[i].ph));
        end
        ld = NO;

        // INIT=7, STEP=5: source yields 7, 12, 4, 9.
        resetb5 = 1'b0; ld5 = NO;
        @(posedge slow_clock); #1;
        resetb5 = 1'b1;
        ld5 = P1; @(posedge slow_clock); #1;
        chk("s5.pcard1", 8'(p1_5), 8'd7);
        ld5 = D1; @(posedge slow_clock); #1;
        chk("s5.dcard1", 8'(d1_5), 8'd12);
        ld5 = P2; @(posedge slow_clock); #1;
        chk("s5.pcard2", 8'(p2_5), 8'd4);
        ld5 = D2; @(posedge slow_clock); #1;
        chk("s5.dcard2", 8'(d2_5), 8'd9);
        chk("s5.pscore", 8'(ps_5), 8'd1);
        chk("s5.dscore", 8'(ds_5), 8'd9);
        chk("s5.cards_dealt", 8'(cd_5), 8'd4);
        chk("s5.seq_error", 8'(err_5), 8'd0);
        chk("s5.pcard3_out", 8'(p3o_5), 8'd0);
        chk("s5.dcard3", 8'(d3_5), 8'd0);
        chk("s5.phase", 8'(ph_5), 8'd4);
        ld5 = NO;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
